// File: rtl/mem_stall_fsm_if.sv
// mem_stall_fsm_if: imem/dmem valid-ready bundle (fetch, load, store).
// master = sequencer side (mem_stall_fsm), slave = memory side.
interface mem_stall_fsm_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W / 8
);
  logic              imem_rreq_valid;
  logic              imem_rreq_ready;
  logic [ADDR_W-1:0] imem_raddr;
  logic              imem_rrsp_valid;
  logic              imem_rrsp_ready;
  logic [DATA_W-1:0] imem_rdata;

  logic              dmem_rreq_valid;
  logic              dmem_rreq_ready;
  logic [ADDR_W-1:0] dmem_raddr;
  logic              dmem_rrsp_valid;
  logic              dmem_rrsp_ready;
  logic [DATA_W-1:0] dmem_rdata;

  logic              dmem_wreq_valid;
  logic              dmem_wreq_ready;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [MASK_W-1:0] dmem_wmask;
  logic              dmem_wrsp_valid;
  logic              dmem_wrsp_ready;

  modport master (
    output imem_rreq_valid, imem_raddr,
    output imem_rrsp_ready,
    output dmem_rreq_valid, dmem_raddr,
    output dmem_rrsp_ready,
    output dmem_wreq_valid, dmem_waddr,
    output dmem_wdata, dmem_wmask,
    output dmem_wrsp_ready,
    input  imem_rreq_ready, imem_rrsp_valid,
    input  imem_rdata,
    input  dmem_rreq_ready, dmem_rrsp_valid,
    input  dmem_rdata,
    input  dmem_wreq_ready, dmem_wrsp_valid
  );

  modport slave (
    input  imem_rreq_valid, imem_raddr,
    input  imem_rrsp_ready,
    input  dmem_rreq_valid, dmem_raddr,
    input  dmem_rrsp_ready,
    input  dmem_wreq_valid, dmem_waddr,
    input  dmem_wdata, dmem_wmask,
    input  dmem_wrsp_ready,
    output imem_rreq_ready, imem_rrsp_valid,
    output imem_rdata,
    output dmem_rreq_ready, dmem_rrsp_valid,
    output dmem_rdata,
    output dmem_wreq_ready, dmem_wrsp_valid
  );
endinterface

// File: rtl/mem_stall_fsm.sv
// mem_stall_fsm: multi-cycle fetch/decode/load/store/commit sequencer.
// Ports: clk, rst (async, active-low), core pc/alu/ctl in, bus (imem/dmem
// master), inst_o/rdata_o latches, stall, commit pulse, sticky err, retired.
module mem_stall_fsm #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = DATA_W / 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic              re_mem,
  input  logic              we_mem,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [MASK_W-1:0] wmask_in,
  mem_stall_fsm_if.master   bus,
  output logic [31:0]       inst_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall,
  output logic              commit,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [3:0] {
    IF_REQ,
    IF_WAIT,
    DEC,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    COMMIT,
    ERR
  } state_t;

  localparam int NI = DATA_W / 32;
  localparam int SW = (NI > 1) ? $clog2(NI) : 1;
  localparam int AL = $clog2(DATA_W / 8);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q;
  logic              entry_q;
  logic [TW-1:0]     tmo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic [ADDR_W-1:0]        pc_sel;
  logic [SW-1:0]            sel;
  logic [NI-1:0][31:0]      words;
  logic                     tmo_hit;
  logic                     req_entry;
  logic                     in_xfer;
  logic                     if_hs, ifr_hs;
  logic                     rd_hs, rdr_hs;
  logic                     wr_hs, wrr_hs;
  logic                     unused_bits;

  // Valid/ready are gated by rst so the reset state (IF_REQ)
  // does not present a request while the core is held in reset.
  assign bus.imem_rreq_valid = rst & (state_q == IF_REQ);
  assign bus.imem_rrsp_ready = rst & (state_q == IF_WAIT);
  assign bus.dmem_rreq_valid = rst & (state_q == RD_REQ);
  assign bus.dmem_rrsp_ready = rst & (state_q == RD_WAIT);
  assign bus.dmem_wreq_valid = rst & (state_q == WR_REQ);
  assign bus.dmem_wrsp_ready = rst & (state_q == WR_WAIT);

  // First IF_REQ cycle: pc_q is not loaded yet, so the address
  // comes straight from the (stalled, stable) core pc.
  assign pc_sel =
    (rst && entry_q && state_q == IF_REQ) ? pc : pc_q;
  assign bus.imem_raddr = {pc_sel[ADDR_W-1:AL], {AL{1'b0}}};

  assign bus.dmem_raddr = addr_q;
  assign bus.dmem_waddr = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_wmask = wmask_q;

  assign words = bus.imem_rdata;
  assign sel   = (NI > 1) ? pc_q[SW+1:2] : '0;

  assign unused_bits = ^{pc_q[1:0], pc_sel[AL-1:0]};

  assign if_hs  = bus.imem_rreq_valid & bus.imem_rreq_ready;
  assign ifr_hs = bus.imem_rrsp_ready & bus.imem_rrsp_valid;
  assign rd_hs  = bus.dmem_rreq_valid & bus.dmem_rreq_ready;
  assign rdr_hs = bus.dmem_rrsp_ready & bus.dmem_rrsp_valid;
  assign wr_hs  = bus.dmem_wreq_valid & bus.dmem_wreq_ready;
  assign wrr_hs = bus.dmem_wrsp_ready & bus.dmem_wrsp_valid;

  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  assign stall  = (state_q != COMMIT);
  assign commit = (state_q == COMMIT);
  assign err    = (state_q == ERR);

  assign in_xfer =
    (state_q == IF_REQ) || (state_q == IF_WAIT) ||
    (state_q == RD_REQ) || (state_q == RD_WAIT) ||
    (state_q == WR_REQ) || (state_q == WR_WAIT);

  assign req_entry = (state_d != state_q) &&
    ((state_d == IF_REQ) || (state_d == RD_REQ) ||
     (state_d == WR_REQ));

  // A completing handshake takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_REQ: begin
        if (if_hs)        state_d = IF_WAIT;
        else if (tmo_hit) state_d = ERR;
      end
      IF_WAIT: begin
        if (ifr_hs)       state_d = DEC;
        else if (tmo_hit) state_d = ERR;
      end
      DEC: begin
        if (re_mem && we_mem) state_d = ERR;
        else if (re_mem)      state_d = RD_REQ;
        else if (we_mem)      state_d = WR_REQ;
        else                  state_d = COMMIT;
      end
      RD_REQ: begin
        if (rd_hs)        state_d = RD_WAIT;
        else if (tmo_hit) state_d = ERR;
      end
      RD_WAIT: begin
        if (rdr_hs)       state_d = COMMIT;
        else if (tmo_hit) state_d = ERR;
      end
      WR_REQ: begin
        if (wr_hs)        state_d = WR_WAIT;
        else if (tmo_hit) state_d = ERR;
      end
      WR_WAIT: begin
        if (wrr_hs)       state_d = COMMIT;
        else if (tmo_hit) state_d = ERR;
      end
      COMMIT:  state_d = IF_REQ;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IF_REQ;
      pc_q    <= '0;
      entry_q <= 1'b1;
      tmo_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      inst_o  <= '0;
      rdata_o <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IF_REQ && entry_q) begin
        pc_q    <= pc;
        entry_q <= 1'b0;
      end else if (state_q == COMMIT) begin
        entry_q <= 1'b1;
      end
      if (req_entry)    tmo_q <= '0;
      else if (in_xfer) tmo_q <= tmo_q + TW'(1);
      if (state_q == DEC) begin
        addr_q  <= alu_res;
        wdata_q <= wdata_in;
        wmask_q <= wmask_in;
      end
      if (ifr_hs) inst_o  <= words[sel];
      if (rdr_hs) rdata_o <= bus.dmem_rdata;
      if (state_q == COMMIT) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stall_fsm.sv
// tb_mem_stall_fsm: directed vectors for mem_stall_fsm (TIMEOUT=8).
// Negedge memory responder with wait/dead knobs; samples #1 after posedge.
module tb_mem_stall_fsm;

  logic        clk;
  logic        rst;
  logic [63:0] pc, alu_res, wdata_in;
  logic [7:0]  wmask_in;
  logic        re_mem, we_mem;
  logic [31:0] inst_o;
  logic [63:0] rdata_o;
  logic        stall, commit, err;
  logic [31:0] retired;

  mem_stall_fsm_if #(.ADDR_W(64), .DATA_W(64), .MASK_W(8)) m ();

  mem_stall_fsm #(
    .ADDR_W(64), .DATA_W(64), .MASK_W(8),
    .TIMEOUT(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .pc(pc), .alu_res(alu_res),
    .re_mem(re_mem), .we_mem(we_mem),
    .wdata_in(wdata_in), .wmask_in(wmask_in),
    .bus(m),
    .inst_o(inst_o), .rdata_o(rdata_o),
    .stall(stall), .commit(commit), .err(err),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] imem_word, load_word;
  int          rd_wait;
  bit          imem_dead, rd_dead;
  int          rd_cnt = 0;
  int          wreq_cnt = 0;
  int          rreq_cyc = 0;
  logic [63:0] cap_waddr = '0, cap_wdata = '0;
  logic [7:0]  cap_wmask = '0;

  always @(negedge clk) begin
    m.imem_rreq_ready = m.imem_rreq_valid;
    m.imem_rrsp_valid = m.imem_rrsp_ready && !imem_dead;
    m.imem_rdata      = imem_word;
    if (m.dmem_rreq_valid) begin
      m.dmem_rreq_ready = (rd_cnt >= rd_wait);
      rd_cnt++;
      rreq_cyc++;
    end else begin
      m.dmem_rreq_ready = 1'b0;
      rd_cnt = 0;
    end
    m.dmem_rrsp_valid = m.dmem_rrsp_ready && !rd_dead;
    m.dmem_rdata      = load_word;
    m.dmem_wreq_ready = m.dmem_wreq_valid;
    m.dmem_wrsp_valid = m.dmem_wrsp_ready;
    if (m.dmem_wreq_valid && m.dmem_wreq_ready) begin
      wreq_cnt++;
      cap_waddr = m.dmem_waddr;
      cap_wdata = m.dmem_wdata;
      cap_wmask = m.dmem_wmask;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
  endtask

  int c;
  bit done;
  int wbase, rbase;

  initial begin
    rst = 1'b0;
    pc = '0; alu_res = '0;
    re_mem = 1'b0; we_mem = 1'b0;
    wdata_in = '0; wmask_in = '0;
    imem_word = 64'h00000013_00500093;
    load_word = 64'h11223344_55667788;
    rd_wait = 0; imem_dead = 0; rd_dead = 0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall",  stall, 1);
    chk("rst_commit", commit, 0);
    chk("rst_err",    err, 0);
    chk("rst_ifval",  m.imem_rreq_valid, 0);
    chk("rst_ret",    retired, 0);
    chk("rst_inst",   inst_o, 0);

    // ALU op at pc 0: commit on cycle 3
    rst = 1'b1;
    #1;
    chk("c0_ifval", m.imem_rreq_valid, 1);
    chk("c0_raddr", m.imem_raddr, 0);
    step(2);
    chk("c2_inst",   inst_o, 64'h00500093);
    chk("c2_commit", commit, 0);
    step(1);
    chk("c3_commit", commit, 1);
    chk("c3_stall",  stall, 0);
    pc = 64'h4;
    step(1);
    chk("c4_ret",    retired, 1);
    chk("c4_commit", commit, 0);
    chk("pc4_raddr", m.imem_raddr, 0);
    step(2);
    chk("pc4_inst", inst_o, 64'h00000013);
    step(1);
    chk("pc4_commit", commit, 1);

    // load with 3 not-ready cycles
    pc = 64'h8; re_mem = 1'b1;
    alu_res = 64'h1008; rd_wait = 3;
    c = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1);
      c++;
      if (m.dmem_rreq_valid)
        chk("ld_raddr", m.dmem_raddr, 64'h1008);
      if (commit) done = 1;
    end
    chk("ld_cycles", c, 9);
    chk("ld_rdata",  rdata_o, 64'h11223344_55667788);

    // store, zero-wait
    re_mem = 1'b0; we_mem = 1'b1; pc = 64'hC;
    alu_res = 64'h2000;
    wdata_in = 64'hDEAD_BEEF; wmask_in = 8'h0F;
    rd_wait = 0;
    wbase = wreq_cnt; rbase = rreq_cyc;
    c = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1);
      c++;
      if (commit) done = 1;
    end
    chk("st_cycles", c, 6);
    chk("st_count",  wreq_cnt - wbase, 1);
    chk("st_waddr",  cap_waddr, 64'h2000);
    chk("st_wdata",  cap_wdata, 64'hDEAD_BEEF);
    chk("st_wmask",  cap_wmask, 8'h0F);
    chk("st_no_rd",  rreq_cyc - rbase, 0);
    chk("st_inst",   inst_o, 64'h00000013);

    // illegal re & we
    pc = 64'h10; re_mem = 1'b1; we_mem = 1'b1;
    wbase = wreq_cnt; rbase = rreq_cyc;
    step(4);
    chk("ill_err",   err, 1);
    chk("ill_stall", stall, 1);
    chk("ill_ret",   retired, 4);
    chk("ill_rdval", m.dmem_rreq_valid, 0);
    chk("ill_wrval", m.dmem_wreq_valid, 0);
    step(3);
    chk("ill_err2",  err, 1);
    chk("ill_stl2",  stall, 1);
    chk("ill_no_rd", rreq_cyc - rbase, 0);
    chk("ill_no_wr", wreq_cnt - wbase, 0);

    // fetch reply never returns
    rst = 1'b0;
    re_mem = 1'b0; we_mem = 1'b0; pc = '0;
    imem_dead = 1;
    release_rst();
    step(7);
    chk("to_err7", err, 0);
    chk("to_rdy7", m.imem_rrsp_ready, 1);
    step(1);
    chk("to_err8", err, 1);
    chk("to_rdy8", m.imem_rrsp_ready, 0);
    chk("to_stl8", stall, 1);
    step(2);
    chk("to_err10", err, 1);
    chk("to_stl10", stall, 1);

    // reset while load reply outstanding
    rst = 1'b0;
    imem_dead = 0; rd_dead = 1;
    re_mem = 1'b1; alu_res = 64'h40;
    release_rst();
    step(4);
    chk("rw_rdy",  m.dmem_rrsp_ready, 1);
    chk("rw_inst", inst_o, 64'h00500093);
    #1 rst = 1'b0;
    #1;
    chk("rw_rdy0",  m.dmem_rrsp_ready, 0);
    chk("rw_rdv0",  m.dmem_rreq_valid, 0);
    chk("rw_ifv0",  m.imem_rreq_valid, 0);
    chk("rw_stall", stall, 1);
    chk("rw_cmt",   commit, 0);
    chk("rw_err",   err, 0);
    chk("rw_inst0", inst_o, 0);
    chk("rw_ret",   retired, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
